fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter sharing one FIFO write port among NUM_REQ requesters. Grants one requester at a time for a burst of up to MAX_BURST accepted words. Muxes the granted requester's data onto the FIFO datain and honours FIFO full backpressure. Sits between producer blocks and the fifo module's write/datain/full pins.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, word width; matches the FIFO's DATA_WIDTH
MAX_BURST, 4, maximum accepted words per grant (>=1)
CNT_WIDTH, 16, width of per-requester statistics counters (optional feature only)

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
req  input  NUM_REQ  per-requester write request; level, held while the requester has data
data  input  NUM_REQ*DATA_WIDTH  requester words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  output  NUM_REQ  word from requester i accepted this cycle
grant  output  NUM_REQ  one-hot current owner; all-zero when idle
fifo_write  output  1  to FIFO write
fifo_datain  output  DATA_WIDTH  to FIFO datain
fifo_full  input  1  from FIFO full
busy  output  1  1 while in GRANT state
stat_cnt  output  NUM_REQ*CNT_WIDTH  accepted-word counts; present only with FIFO_ARB_STATS_EN

Behaviour:
- States: IDLE (grant=0) and GRANT (grant one-hot, registered). Registered state: state, grant, rr_ptr (log2 NUM_REQ bits), beat_cnt (0..MAX_BURST-1).
- Reset (reset=0, async): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0. Outputs ack=0, fifo_write=0, busy=0, fifo_datain=0 (mux defaults to 0 when grant=0), stat_cnt=0. Applies mid-burst; the in-flight word is dropped from arbiter view.
- Beat (combinational): beat = |(grant & req) & ~fifo_full. fifo_write=beat; ack[i]=grant[i] & req[i] & ~fifo_full; fifo_datain = data word of the granted index (0 if none). The FIFO captures the word on the same edge; requester may present its next word after ack.
- Arbitration: search req starting at rr_ptr, ascending with wrap mod NUM_REQ; first set bit wins.
- IDLE: if any req, next edge -> GRANT with the winner, beat_cnt=0. One-cycle arbitration latency from req to grant.
- GRANT release condition, evaluated in the current cycle: req[g]=0, or (beat and beat_cnt==MAX_BURST-1).
- On release at the edge: rr_ptr <= g+1 (wrap). Re-arbitrate with the updated pointer on the current req. If any req is set, the new grant takes effect on that edge with no idle gap, and the same requester is regranted if it is the only one requesting. Otherwise -> IDLE. beat_cnt <= 0.
- No release: beat_cnt increments on beat only.
- fifo_full=1 in GRANT: no beat, ack=0, beat_cnt holds, grant held. A stall never forces release; a req drop during a stall still releases.
- req[g] dropping mid-burst: no beat that cycle; release at the next edge.
- A requester must not drop req in a cycle where it is acked unless finished; ack-then-drop is legal.

Optional Feature:
FIFO_ARB_STATS_EN: when defined, stat_cnt port and NUM_REQ counters of CNT_WIDTH bits are present. Counter i increments on each ack[i] and wraps modulo 2^CNT_WIDTH. Counters clear on reset. When undefined, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset low with req=4'hF -> grant=0, fifo_write=0, ack=0, busy=0. Reset high -> grant=4'b0001 one edge later.
2. Only req[1] held, data1 incrementing from 8'h10, no full -> grant=4'b0010 after 1 cycle. fifo_write high every cycle thereafter, including across the regrant at each 4-beat boundary. FIFO receives 10,11,12,...
3. req[0] and req[2] held (data 8'hA0.., 8'hC0..) -> bursts alternate: 4 words A0-A3, 4 words C0-C3, then A4-A7. No gap cycle between bursts.
4. req[3] alone; fifo_full=1 for 3 cycles after the 2nd beat -> fifo_write=0 and ack=0 for those 3 cycles, grant stays 4'b1000. Exactly 4 words total before release.
5. req[2] drops after 2 accepted words while req[0] held -> grant moves to 4'b0001 at the next edge, rr_ptr=3.
6. Reset pulled low mid-burst between clock edges -> grant, busy, fifo_write go 0 before the next posedge. stat_cnt reads 0 when FIFO_ARB_STATS_EN is defined.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
// Optional FIFO_ARB_STATS_EN adds per-requester accepted-word counters on stat_cnt.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   data,
  output logic [NUM_REQ-1:0]              ack,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            fifo_write,
  output logic [DATA_WIDTH-1:0]           fifo_datain,
  input  logic                            fifo_full,
  output logic                            busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    stat_cnt
`endif
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  if (NUM_REQ < 2 || MAX_BURST < 1 || CNT_WIDTH < 1) begin : g_bad_params
    $error("fifo_wr_arbiter: illegal parameter combination");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              state, state_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_n;
  logic [BEAT_W-1:0]   beat_cnt, beat_cnt_n;
  logic [PTR_W-1:0]    owner_idx, next_ptr, arb_ptr;
  logic [NUM_REQ-1:0]  win_onehot;
  logic                win_found;
  logic                owner_req, beat, rel_now;

  always_comb begin
    owner_idx   = '0;
    fifo_datain = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner_idx   = PTR_W'(i);
        fifo_datain = data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign owner_req  = |(grant & req);
  assign beat       = owner_req & ~fifo_full;
  assign ack        = grant & req & {NUM_REQ{~fifo_full}};
  assign fifo_write = beat;
  assign busy       = (state == S_GRANT);
  assign rel_now    = (state == S_GRANT) && (!owner_req || (beat && beat_cnt == LAST_BEAT));
  assign next_ptr   = (owner_idx == LAST_IDX) ? '0 : owner_idx + PTR_W'(1);

  // A releasing owner re-arbitrates from the advanced pointer in the same cycle.
  assign arb_ptr = (state == S_GRANT) ? next_ptr : rr_ptr;

  always_comb begin
    int idx;
    idx        = 0;
    win_found  = 1'b0;
    win_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(arb_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found       = 1'b1;
        win_onehot[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_n    = S_GRANT;
          grant_n    = win_onehot;
          beat_cnt_n = '0;
        end
      end
      S_GRANT: begin
        if (rel_now) begin
          rr_ptr_n   = next_ptr;
          beat_cnt_n = '0;
          if (win_found) begin
            grant_n = win_onehot;
          end else begin
            state_n = S_IDLE;
            grant_n = '0;
          end
        end else if (beat) begin
          beat_cnt_n = beat_cnt + BEAT_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i]) stat_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= stat_cnt[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized bench for fifo_wr_arbiter against an integer reference model
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = 16;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ack;
  logic [N-1:0]    grant;
  logic            fifo_write;
  logic [DW-1:0]   fifo_datain;
  logic            fifo_full;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*CW-1:0] stat_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .grant       (grant),
    .fifo_write  (fifo_write),
    .fifo_datain (fifo_datain),
    .fifo_full   (fifo_full),
    .busy        (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_cnt    (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner index (-1 when idle), search pointer, words in current burst.
  int         m_owner;
  int         m_ptr;
  int         m_cnt;
  int         sent [N];
  int         stat [N];
  logic [7:0] base [N];
  int         phase_writes;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    for (int i = 0; i < N; i++) stat[i] = 0;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic f);
    req       = r;
    fifo_full = f;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = base[i] + 8'(sent[i]);
  endtask

  task automatic check_stats();
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      logic [CW-1:0] s;
      s = stat_cnt[i*CW +: CW];
      check($sformatf("stat_cnt[%0d]", i), 64'(s), 64'(stat[i] % (1 << CW)));
    end
`endif
  endtask

  // Check outputs mid-cycle, then advance the model on the coming posedge.
  task automatic step();
    logic [N-1:0]  e_grant;
    logic [N-1:0]  e_ack;
    logic [DW-1:0] e_dat;
    bit            e_beat;
    bit            rel;
    @(negedge clk);
    e_grant = '0;
    e_ack   = '0;
    e_dat   = '0;
    e_beat  = 1'b0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_dat  = base[m_owner] + 8'(sent[m_owner]);
      e_beat = req[m_owner] && !fifo_full;
      if (e_beat) e_ack[m_owner] = 1'b1;
    end
    check("grant", 64'(grant), 64'(e_grant));
    check("ack", 64'(ack), 64'(e_ack));
    check("fifo_write", 64'(fifo_write), 64'(e_beat));
    check("fifo_datain", 64'(fifo_datain), 64'(e_dat));
    check("busy", 64'(busy), 64'(m_owner >= 0));
    check_stats();
    if (fifo_write) phase_writes++;
    if (m_owner < 0) begin
      m_owner = first_from(m_ptr, req);
      m_cnt   = 0;
    end else begin
      rel = !req[m_owner] || (e_beat && m_cnt == MB - 1);
      if (e_beat) begin
        sent[m_owner]++;
        stat[m_owner]++;
      end
      if (rel) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = first_from(m_ptr, req);
        m_cnt   = 0;
      end else if (e_beat) begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Called between edges: reset must clear outputs asynchronously.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_fifo_write", 64'(fifo_write), 64'(0));
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_datain", 64'(fifo_datain), 64'(0));
    model_reset();
    check_stats();
    @(posedge clk);
    #1;
    check("rst_hold_grant", 64'(grant), 64'(0));
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    base[0] = 8'hA0;
    base[1] = 8'h10;
    base[2] = 8'hC0;
    base[3] = 8'h30;
    for (int i = 0; i < N; i++) sent[i] = 0;
    model_reset();
    reset = 1'b0;
    drive(4'hF, 1'b0);
    @(posedge clk);
    #3;
    do_reset();
    drive(4'hF, 1'b0);
    step();
    step();

    do_reset();
    phase_writes = 0;
    for (int c = 0; c < 14; c++) begin
      drive(4'b0010, 1'b0);
      step();
    end
    check("single_req_stream_writes", 64'(phase_writes), 64'(13));

    for (int c = 0; c < 20; c++) begin
      drive(4'b0101, 1'b0);
      step();
    end

    for (int c = 0; c < 24; c++) begin
      drive(4'b1000, ($urandom_range(0, 2) == 0));
      step();
    end

    for (int c = 0; c < 3; c++) begin
      drive(4'b0110, 1'b0);
      step();
    end
    #2;
    do_reset();

    r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      r = r ^ 4'($urandom & $urandom & $urandom);
      drive(r, ($urandom_range(0, 3) == 0));
      step();
      if (c == 1500) begin
        #2;
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
